xbar_switch_nport: RTL and testbench
====================================

Name: xbar_switch_nport

Overview:
- Parametrised N-input / N-output packet switch. Successor to the fixed-size lab DUT.
- Each input port has its own FIFO. Each output port has a round-robin arbiter and a one-word output register.
- Adds three things the earlier DUT lacks: configurable port count, width and depth; per-output fairness; and invalid-destination drop counting.
- Instantiated under dut_top and driven by the class-based bench (driver, monitor, scoreboard, coverage).

Parameters:
- NUM_PORTS, 4, number of input ports and output ports (2..8).
- DATA_W, 8, payload width in bits.
- FIFO_DEPTH, 4, words per input FIFO (power of 2, >=2).
- DEST_W (localparam), max(1, $clog2(NUM_PORTS)), width of destination/source fields.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  NUM_PORTS  per-input word valid.
- in_dest  input  NUM_PORTS*DEST_W  per-input destination port, slice i belongs to input i.
- in_data  input  NUM_PORTS*DATA_W  per-input payload.
- in_ready  output  NUM_PORTS  per-input FIFO-not-full.
- out_valid  output  NUM_PORTS  per-output word valid.
- out_data  output  NUM_PORTS*DATA_W  per-output payload.
- out_src  output  NUM_PORTS*DEST_W  input port the word came from.
- out_ready  input  NUM_PORTS  per-output consumer accept.
- drop_cnt  output  16  saturating count of invalid-destination words.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- While reset is high at a clock edge, all state clears:
  - FIFOs empty.
  - out_valid=0, out_data=0, out_src=0.
  - Arbiter pointers=0, drop_cnt=0.
  - in_ready is forced 0 while reset is high.
- Reset mid-operation discards all buffered and registered words; no partial delivery afterwards.

Input side:
- in_ready[i] = !reset && (count_i < FIFO_DEPTH). It depends on count only; a same-cycle pop does not raise it.
- Push occurs when in_valid[i] && in_ready[i].
- If in_dest[i] >= NUM_PORTS, the word is consumed but not stored. drop_cnt increments and saturates at 16'hFFFF.

Arbitration, per output j:
- req[i] = FIFO i non-empty && head_dest_i == j.
- Grant goes to the first requesting i found searching from ptr[j] upward, mod NUM_PORTS.
- On a grant, ptr[j] <= (grant+1) mod NUM_PORTS. With no grant, ptr[j] holds.
- Load enable for output j: !out_valid[j] || out_ready[j]. Arbitration happens only when load is enabled.
- On a grant: pop FIFO i, then out_data[j]<=head data, out_src[j]<=i, out_valid[j]<=1.
- If load is enabled with no grant: out_valid[j]<=0; out_data and out_src hold.
- Each FIFO head targets exactly one output, so at most one pop per FIFO per cycle. All outputs arbitrate in parallel.

Output side:
- out_valid[j], out_data[j] and out_src[j] stay stable while out_valid[j]=1 and out_ready[j]=0.
- Latency: a word pushed at edge k into an empty FIFO, toward an idle output, shows out_valid at edge k+1.
- Simultaneous push and pop on the same FIFO are both honoured; count stays the same.

Ordering and known limits:
- Order is preserved per (input, output) pair.
- Head-of-line blocking across destinations is accepted behaviour.
- Capacity per input toward a stalled output is FIFO_DEPTH + 1 (the extra word sits in the output register).

Test Plan:
- Single word: input0 sends dest=2, data=8'hA5 at edge k.
  -> out_valid[2]=1 after edge k+1, out_data[2]=A5, out_src[2]=0. All other out_valid stay 0.
- Contention: inputs 0,1,3 each send one word to dest 1 in the same cycle, out_ready=all 1.
  -> Output 1 delivers src 0, then 1, then 3 on consecutive cycles; ptr[1] ends at 0.
  -> A second identical burst is delivered in the same order.
- Backpressure: out_ready[0]=0; input2 offers 6 words (0x10..0x15) to dest 0.
  -> Exactly 5 accepted, then in_ready[2]=0; out_data[0]=0x10 held stable.
  -> Raise out_ready[0]: 0x10..0x15 delivered in order, in_ready[2] reasserts.
- Invalid destination, NUM_PORTS=3: send dest=3 three times.
  -> drop_cnt=3, no out_valid, in_ready stays 1.
- Parallel traffic: inputs 0..3 send to dests 3,2,1,0 in the same cycle.
  -> All four out_valid rise together after one edge, out_src = 3,2,1,0 respectively.
- Reset mid-traffic: assert reset for 1 cycle with FIFOs and outputs holding data.
  -> Next cycle all out_valid=0, drop_cnt=0, in_ready=all 1; no stale word ever emerges.

Source files
------------

// File: rtl/xbar_switch_nport.sv
// -----------------------------------------------------------------------------
// xbar_switch_nport
// Parametrised NUM_PORTS x NUM_PORTS packet switch. Each input buffers words in
// its own FIFO. Each output has a round-robin arbiter and a one-word output
// register. A word whose destination is >= NUM_PORTS is accepted and discarded,
// and the event is counted in a saturating 16-bit counter.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   reset      : synchronous, active-high; clears all state, forces in_ready=0
//   in_valid   : [NUM_PORTS]         per-input word valid
//   in_dest    : [NUM_PORTS*DEST_W]  per-input destination, slice i = input i
//   in_data    : [NUM_PORTS*DATA_W]  per-input payload
//   in_ready   : [NUM_PORTS]         per-input FIFO not full
//   out_valid  : [NUM_PORTS]         per-output word valid
//   out_data   : [NUM_PORTS*DATA_W]  per-output payload
//   out_src    : [NUM_PORTS*DEST_W]  input port the word came from
//   out_ready  : [NUM_PORTS]         per-output consumer accept
//   drop_cnt   : [16]                saturating count of invalid-destination words
// -----------------------------------------------------------------------------
module xbar_switch_nport #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int DEST_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS*DEST_W-1:0]   in_dest,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic [NUM_PORTS-1:0]          out_valid,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [NUM_PORTS*DEST_W-1:0]   out_src,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [15:0]                   drop_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [DEST_W:0]   PORTS_C   = (DEST_W + 1)'(NUM_PORTS);
    localparam logic [DEST_W-1:0] LAST_PORT = DEST_W'(NUM_PORTS - 1);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [DEST_W-1:0] port_t;

    // Packed views of the flat per-port buses.
    logic [NUM_PORTS-1:0][DEST_W-1:0] in_dest_s;
    logic [NUM_PORTS-1:0][DATA_W-1:0] in_data_s;

    // Per-input FIFO state.
    data_t            mem_data_q [NUM_PORTS][FIFO_DEPTH];
    data_t            mem_data_d [NUM_PORTS][FIFO_DEPTH];
    port_t            mem_dest_q [NUM_PORTS][FIFO_DEPTH];
    port_t            mem_dest_d [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q   [NUM_PORTS];
    logic [PTR_W-1:0] rd_ptr_d   [NUM_PORTS];
    logic [PTR_W-1:0] wr_ptr_q   [NUM_PORTS];
    logic [PTR_W-1:0] wr_ptr_d   [NUM_PORTS];
    logic [CNT_W-1:0] count_q    [NUM_PORTS];
    logic [CNT_W-1:0] count_d    [NUM_PORTS];

    // Per-output arbiter pointer and output register.
    port_t                            arb_ptr_q [NUM_PORTS];
    port_t                            arb_ptr_d [NUM_PORTS];
    logic [NUM_PORTS-1:0]             out_valid_q, out_valid_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] out_data_q, out_data_d;
    logic [NUM_PORTS-1:0][DEST_W-1:0] out_src_q, out_src_d;
    logic [15:0]                      drop_cnt_q, drop_cnt_d;

    logic [NUM_PORTS-1:0]                not_full_s;
    logic [NUM_PORTS-1:0]                push_s;
    logic [NUM_PORTS-1:0]                keep_s;
    logic [NUM_PORTS-1:0]                pop_s;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_s;      // req_s[j][i]: input i wants output j
    logic [DEST_W:0]                     pick_s;     // {found, grant}
    port_t                               grant_s;
    logic [DEST_W:0]                     n_drop_s;
    logic [16:0]                         drop_sum_s;

    // Successor of a port index, wrapping at NUM_PORTS.
    function automatic port_t next_port(input port_t p);
        port_t r;
        if (p == LAST_PORT) begin
            r = {DEST_W{1'b0}};
        end else begin
            r = p + DEST_W'(1);
        end
        return r;
    endfunction

    // Round-robin pick: first requester at or after ptr, wrapping. Returns {found, index}.
    function automatic logic [DEST_W:0] rr_pick(input logic [NUM_PORTS-1:0] req, input port_t ptr);
        logic  found;
        port_t idx;
        port_t cand;
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 32'sd0; k < NUM_PORTS; k++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
            cand = next_port(cand);
        end
        return {found, idx};
    endfunction

    assign in_dest_s = in_dest;
    assign in_data_s = in_data;

    // in_ready follows FIFO occupancy only; a same-cycle pop does not raise it.
    assign in_ready  = not_full_s & ~{NUM_PORTS{reset}};
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign drop_cnt  = drop_cnt_q;

    // FIFO status, accepted/stored pushes and per-output request matrix.
    always_comb begin
        not_full_s = {NUM_PORTS{1'b0}};
        push_s     = {NUM_PORTS{1'b0}};
        keep_s     = {NUM_PORTS{1'b0}};
        req_s      = {(NUM_PORTS * NUM_PORTS){1'b0}};
        for (int i = 32'sd0; i < NUM_PORTS; i++) begin
            not_full_s[i] = (count_q[i] < DEPTH_C);
            push_s[i]     = in_valid[i] && not_full_s[i] && !reset;
            keep_s[i]     = push_s[i] && ({1'b0, in_dest_s[i]} < PORTS_C);
            for (int j = 32'sd0; j < NUM_PORTS; j++) begin
                req_s[j][i] = (count_q[i] != {CNT_W{1'b0}}) &&
                              (mem_dest_q[i][rd_ptr_q[i]] == port_t'(j));
            end
        end
    end

    // Output arbitration: every output with load enabled picks in parallel.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        arb_ptr_d   = arb_ptr_q;
        pop_s       = {NUM_PORTS{1'b0}};
        pick_s      = {(DEST_W + 1){1'b0}};
        grant_s     = {DEST_W{1'b0}};
        for (int j = 32'sd0; j < NUM_PORTS; j++) begin
            if (!out_valid_q[j] || out_ready[j]) begin
                pick_s  = rr_pick(req_s[j], arb_ptr_q[j]);
                grant_s = pick_s[DEST_W-1:0];
                if (pick_s[DEST_W]) begin
                    pop_s[grant_s] = 1'b1;
                    out_valid_d[j] = 1'b1;
                    out_data_d[j]  = mem_data_q[grant_s][rd_ptr_q[grant_s]];
                    out_src_d[j]   = grant_s;
                    arb_ptr_d[j]   = next_port(grant_s);
                end else begin
                    out_valid_d[j] = 1'b0;
                end
            end else begin
                out_valid_d[j] = out_valid_q[j];
            end
        end
    end

    // FIFO write/read pointers, occupancy and the drop counter.
    always_comb begin
        mem_data_d = mem_data_q;
        mem_dest_d = mem_dest_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        n_drop_s   = {(DEST_W + 1){1'b0}};
        for (int i = 32'sd0; i < NUM_PORTS; i++) begin
            if (keep_s[i]) begin
                mem_data_d[i][wr_ptr_q[i]] = in_data_s[i];
                mem_dest_d[i][wr_ptr_q[i]] = in_dest_s[i];
                wr_ptr_d[i]                = wr_ptr_q[i] + PTR_W'(1);
            end else if (push_s[i]) begin
                n_drop_s = n_drop_s + (DEST_W + 1)'(1);
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i];
            end
            if (pop_s[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end else begin
                rd_ptr_d[i] = rd_ptr_q[i];
            end
            case ({keep_s[i], pop_s[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
        drop_sum_s = {1'b0, drop_cnt_q} + 17'(n_drop_s);
        if (drop_sum_s[16]) begin
            drop_cnt_d = 16'hFFFF;
        end else begin
            drop_cnt_d = drop_sum_s[15:0];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 32'sd0; i < NUM_PORTS; i++) begin
                for (int k = 32'sd0; k < FIFO_DEPTH; k++) begin
                    mem_data_q[i][k] <= {DATA_W{1'b0}};
                    mem_dest_q[i][k] <= {DEST_W{1'b0}};
                end
                rd_ptr_q[i]  <= {PTR_W{1'b0}};
                wr_ptr_q[i]  <= {PTR_W{1'b0}};
                count_q[i]   <= {CNT_W{1'b0}};
                arb_ptr_q[i] <= {DEST_W{1'b0}};
            end
            out_valid_q <= {NUM_PORTS{1'b0}};
            out_data_q  <= {(NUM_PORTS * DATA_W){1'b0}};
            out_src_q   <= {(NUM_PORTS * DEST_W){1'b0}};
            drop_cnt_q  <= 16'h0000;
        end else begin
            mem_data_q  <= mem_data_d;
            mem_dest_q  <= mem_dest_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            arb_ptr_q   <= arb_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_xbar_switch_nport.sv
// -----------------------------------------------------------------------------
// tb_xbar_switch_nport
// Self-checking bench for xbar_switch_nport. A 4-port instance is compared every
// cycle against a queue-based reference model; a table of single-shot vectors,
// hand sequences (contention, backpressure, reset) and random traffic drive it.
// A 3-port instance exercises invalid-destination dropping.
// -----------------------------------------------------------------------------
module tb_xbar_switch_nport;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_dest, out_src;
    logic [31:0] in_data, out_data;
    logic [15:0] drop_cnt;

    logic [2:0]  in_valid3, in_ready3, out_valid3, out_ready3;
    logic [5:0]  in_dest3, out_src3;
    logic [23:0] in_data3, out_data3;
    logic [15:0] drop_cnt3;

    int n_err = 0;
    int n_chk = 0;

    xbar_switch_nport #(.NUM_PORTS(4), .DATA_W(8), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_dest(in_dest), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
        .drop_cnt(drop_cnt)
    );

    xbar_switch_nport #(.NUM_PORTS(3), .DATA_W(8), .FIFO_DEPTH(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid3), .in_dest(in_dest3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_src(out_src3), .out_ready(out_ready3),
        .drop_cnt(drop_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed { logic [1:0] dest; logic [7:0] data; } word_t;
    word_t      mq [4][$];
    bit         m_ov [4];
    logic [7:0] m_od [4];
    logic [1:0] m_os [4];
    int         m_ptr [4];
    int         m_drop;

    task automatic model_step();
        int sz [4];
        bit take [4];
        int g;
        bit found;
        word_t w;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                m_ov[i] = 1'b0; m_od[i] = 8'h00; m_os[i] = 2'd0; m_ptr[i] = 0;
            end
            m_drop = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                sz[i] = mq[i].size();
                take[i] = 1'b0;
            end
            for (int j = 0; j < N; j++) begin
                if (!m_ov[j] || out_ready[j]) begin
                    found = 1'b0; g = 0;
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i = (m_ptr[j] + k) % N;
                        if (!found && sz[i] > 0 && int'(mq[i][0].dest) == j) begin
                            found = 1'b1; g = i;
                        end
                    end
                    if (found) begin
                        m_ov[j] = 1'b1; m_od[j] = mq[g][0].data; m_os[j] = 2'(g);
                        m_ptr[j] = (g + 1) % N; take[g] = 1'b1;
                    end else begin
                        m_ov[j] = 1'b0;
                    end
                end
            end
            for (int i = 0; i < N; i++) if (take[i]) void'(mq[i].pop_front());
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && sz[i] < DEPTH) begin
                    w.dest = in_dest[2*i +: 2];
                    w.data = in_data[8*i +: 8];
                    if (int'(w.dest) < N) mq[i].push_back(w);
                    else if (m_drop < 65535) m_drop++;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < N; j++) begin
            chk($sformatf("out_valid[%0d]", j), 32'(out_valid[j]), 32'(m_ov[j]));
            chk($sformatf("out_data[%0d]", j), 32'(out_data[8*j +: 8]), 32'(m_od[j]));
            chk($sformatf("out_src[%0d]", j), 32'(out_src[2*j +: 2]), 32'(m_os[j]));
            chk($sformatf("in_ready[%0d]", j), 32'(in_ready[j]),
                32'(!reset && mq[j].size() < DEPTH));
        end
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  vin;
        logic [7:0]  dest;
        logic [31:0] data;
        logic [3:0]  exp_ov;
        logic [7:0]  exp_src;
        logic [31:0] exp_data;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] smask;
    logic [31:0] dmask;
    int         w;
    bit         rdy, vld;
    logic [7:0] got [$];
    int         exp_src [3];
    logic [7:0] exp_dat [3];

    initial begin
        vecs[0] = '{4'b0001, 8'h02, 32'h000000A5, 4'b0100, 8'h00, 32'h00A50000};
        vecs[1] = '{4'b1111, 8'h1B, 32'h44332211, 4'b1111, 8'h1B, 32'h11223344};
        vecs[2] = '{4'b1000, 8'h00, 32'h5A000000, 4'b0001, 8'h03, 32'h0000005A};
        vecs[3] = '{4'b0010, 8'h0C, 32'h0000C300, 4'b1000, 8'h40, 32'hC3000000};
        vecs[4] = '{4'b0101, 8'h22, 32'h00770066, 4'b0100, 8'h20, 32'h00770000};

        in_valid = 4'h0; in_dest = 8'h00; in_data = 32'h0; out_ready = 4'hF;
        in_valid3 = 3'b000; in_dest3 = 6'h00; in_data3 = 24'h0; out_ready3 = 3'b111;
        reset = 1'b1;
        m_drop = 0;
        step();
        step();
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_in_ready_low", 32'(in_ready), 32'h0);
        chk("reset_drop", 32'(drop_cnt), 32'h0);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'hF);

        // Table: one push edge, one delivery edge, then drain.
        for (int v = 0; v < 5; v++) begin
            in_valid = vecs[v].vin; in_dest = vecs[v].dest; in_data = vecs[v].data;
            step();
            in_valid = 4'h0;
            step();
            smask = 8'h00; dmask = 32'h0;
            for (int j = 0; j < N; j++) begin
                if (vecs[v].exp_ov[j]) begin
                    smask[2*j +: 2] = 2'b11;
                    dmask[8*j +: 8] = 8'hFF;
                end
            end
            chk($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
            chk($sformatf("vec%0d_out_src", v), 32'(out_src & smask), 32'(vecs[v].exp_src));
            chk($sformatf("vec%0d_out_data", v), out_data & dmask, vecs[v].exp_data);
            for (int d = 0; d < 3; d++) step();
        end

        // Contention: inputs 0,1,3 to output 1, twice, starting from ptr=0.
        reset = 1'b1; step(); reset = 1'b0;
        exp_src = '{0, 1, 3};
        exp_dat = '{8'h11, 8'h22, 8'h44};
        for (int b = 0; b < 2; b++) begin
            in_valid = 4'b1011; in_dest = 8'h45; in_data = 32'h44002211;
            step();
            in_valid = 4'h0;
            for (int k = 0; k < 3; k++) begin
                step();
                chk($sformatf("cont%0d_valid%0d", b, k), 32'(out_valid[1]), 32'h1);
                chk($sformatf("cont%0d_src%0d", b, k), 32'(out_src[3:2]), 32'(exp_src[k]));
                chk($sformatf("cont%0d_data%0d", b, k), 32'(out_data[15:8]), 32'(exp_dat[k]));
            end
            step();
            chk($sformatf("cont%0d_idle", b), 32'(out_valid[1]), 32'h0);
        end

        // Backpressure: output 0 stalled, input 2 offers 0x10..0x15.
        out_ready = 4'b1110; in_dest = 8'h00; w = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (w < 6) ? 4'b0100 : 4'b0000;
            in_data = {8'h00, 8'(16 + w), 16'h0000};
            rdy = in_ready[2]; vld = in_valid[2];
            step();
            if (rdy && vld) w++;
        end
        chk("bp_accepted", 32'(w), 32'd5);
        chk("bp_in_ready_low", 32'(in_ready[2]), 32'h0);
        chk("bp_head_valid", 32'(out_valid[0]), 32'h1);
        chk("bp_head_data", 32'(out_data[7:0]), 32'h10);
        out_ready = 4'hF;
        got.delete();
        for (int c = 0; c < 30 && got.size() < 6; c++) begin
            in_valid = (w < 6) ? 4'b0100 : 4'b0000;
            in_data = {8'h00, 8'(16 + w), 16'h0000};
            rdy = in_ready[2]; vld = in_valid[2];
            if (out_valid[0]) got.push_back(out_data[7:0]);
            step();
            if (rdy && vld) w++;
        end
        in_valid = 4'h0;
        chk("bp_delivered_count", 32'(got.size()), 32'd6);
        for (int k = 0; k < got.size(); k++)
            chk($sformatf("bp_order%0d", k), 32'(got[k]), 32'(16 + k));
        chk("bp_in_ready_back", 32'(in_ready[2]), 32'h1);

        // Reset with buffered and registered words.
        out_ready = 4'h0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 4'($urandom); in_dest = 8'($urandom); in_data = $urandom;
            step();
        end
        in_valid = 4'h0;
        reset = 1'b1;
        step();
        chk("mid_reset_out_valid", 32'(out_valid), 32'h0);
        chk("mid_reset_in_ready", 32'(in_ready), 32'h0);
        reset = 1'b0;
        #1;
        chk("after_reset_in_ready", 32'(in_ready), 32'hF);
        chk("after_reset_drop", 32'(drop_cnt), 32'h0);
        out_ready = 4'hF;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("no_stale_word", 32'(out_valid), 32'h0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            in_valid = 4'($urandom); in_dest = 8'($urandom); in_data = $urandom;
            for (int j = 0; j < N; j++) out_ready[j] = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0; in_valid = 4'h0; out_ready = 4'hF;

        // Invalid destination on the 3-port instance.
        reset = 1'b1; step(); reset = 1'b0;
        chk("drop3_reset", 32'(drop_cnt3), 32'h0);
        in_valid3 = 3'b001; in_dest3 = 6'b000011; in_data3 = 24'h0000EE;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("drop3_cnt%0d", k), 32'(drop_cnt3), 32'(k));
            chk($sformatf("drop3_no_valid%0d", k), 32'(out_valid3), 32'h0);
            chk($sformatf("drop3_ready%0d", k), 32'(in_ready3), 32'h7);
        end
        in_valid3 = 3'b111; in_dest3 = 6'b111111;
        step();
        chk("drop3_parallel", 32'(drop_cnt3), 32'd6);
        in_valid3 = 3'b001; in_dest3 = 6'b000010; in_data3 = 24'h0000AB;
        step();
        in_valid3 = 3'b000;
        step();
        chk("drop3_valid_word", 32'(out_valid3), 32'h4);
        chk("drop3_valid_data", 32'(out_data3[23:16]), 32'hAB);
        chk("drop3_valid_src", 32'(out_src3[5:4]), 32'h0);
        chk("drop3_cnt_hold", 32'(drop_cnt3), 32'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
